// File: rtl/drain_pkg.sv
// Shared constants and types for the output drain stage and its round-robin arbiter.
package drain_pkg;
  localparam int DATA_W    = 10;
  localparam int NPORT     = 4;
  // External name of local port 0 (ports 4..7 map to indices 0..3).
  localparam int PORT_BASE = 4;

  typedef logic [1:0] port_idx_t;
endpackage

// File: rtl/rr_arbiter4.sv
// Four-request round-robin arbiter: grants the first request found scanning upward from ptr+1.
module rr_arbiter4
  import drain_pkg::*;
(
  input  logic [NPORT-1:0] req,
  input  port_idx_t        ptr,
  input  logic             en,
  output logic [NPORT-1:0] grant,
  output port_idx_t        grant_idx
);

  logic      found;
  port_idx_t cand;

  always_comb begin
    grant     = '0;
    grant_idx = ptr;
    found     = 1'b0;
    cand      = ptr;
    // i = NPORT wraps back to ptr itself, so it is searched last.
    for (int i = 1; i <= NPORT; i++) begin
      cand = ptr + port_idx_t'(i);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    if (en && found) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/output_drain_rr.sv
// Drains output FIFOs 4..7 round-robin into one tagged valid/ready stream with per-port counters.
module output_drain_rr
  import drain_pkg::*;
#(
  parameter int DATA_W = drain_pkg::DATA_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              empty4,
  input  logic              empty5,
  input  logic              empty6,
  input  logic              empty7,
  input  logic [DATA_W-1:0] fifo_data4,
  input  logic [DATA_W-1:0] fifo_data5,
  input  logic [DATA_W-1:0] fifo_data6,
  input  logic [DATA_W-1:0] fifo_data7,
  output logic              pop4,
  output logic              pop5,
  output logic              pop6,
  output logic              pop7,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        src_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [CNT_W-1:0]  cnt4,
  output logic [CNT_W-1:0]  cnt5,
  output logic [CNT_W-1:0]  cnt6,
  output logic [CNT_W-1:0]  cnt7,
  output logic              idle
);

  logic [NPORT-1:0]  empty_vec;
  logic [NPORT-1:0]  grant;
  logic [DATA_W-1:0] fifo_data_arr [NPORT];
  logic [CNT_W-1:0]  cnt_reg [NPORT];
  port_idx_t         grant_idx;
  port_idx_t         ptr_reg;
  port_idx_t         infl_src_reg;
  logic              infl_reg;
  logic [1:0]        occ_reg;
  logic [DATA_W-1:0] head_data_reg, tail_data_reg;
  port_idx_t         head_src_reg, tail_src_reg;
  logic              deq, enq, credit_ok, pop_en;
  logic [DATA_W-1:0] cap_data;

  assign empty_vec        = {empty7, empty6, empty5, empty4};
  assign fifo_data_arr[0] = fifo_data4;
  assign fifo_data_arr[1] = fifo_data5;
  assign fifo_data_arr[2] = fifo_data6;
  assign fifo_data_arr[3] = fifo_data7;

  assign valid_out = (occ_reg != 2'd0);
  assign deq       = valid_out && ready_in;

  // Buffered plus in-flight words, minus the one leaving now, must stay below two.
  assign credit_ok = ({1'b0, occ_reg} + {2'b00, infl_reg}) < (3'd2 + {2'b00, deq});
  assign pop_en    = reset && !init && credit_ok;

  rr_arbiter4 u_arb (
    .req       (~empty_vec),
    .ptr       (ptr_reg),
    .en        (pop_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign {pop7, pop6, pop5, pop4} = grant;

  assign enq      = infl_reg;
  assign cap_data = fifo_data_arr[infl_src_reg];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_reg      <= 2'd3;
      infl_reg     <= 1'b0;
      infl_src_reg <= 2'd0;
    end else begin
      infl_reg <= |grant;
      if (|grant) begin
        ptr_reg      <= grant_idx;
        infl_src_reg <= grant_idx;
      end
    end
  end

  // Two-entry buffer: head drives the output, tail only fills while the head is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_reg       <= 2'd0;
      head_data_reg <= '0;
      head_src_reg  <= 2'd0;
      tail_data_reg <= '0;
      tail_src_reg  <= 2'd0;
    end else begin
      case ({enq, deq})
        2'b10: begin
          if (occ_reg == 2'd0) begin
            head_data_reg <= cap_data;
            head_src_reg  <= infl_src_reg;
          end else begin
            tail_data_reg <= cap_data;
            tail_src_reg  <= infl_src_reg;
          end
          occ_reg <= occ_reg + 2'd1;
        end
        2'b01: begin
          head_data_reg <= tail_data_reg;
          head_src_reg  <= tail_src_reg;
          occ_reg       <= occ_reg - 2'd1;
        end
        2'b11: begin
          if (occ_reg == 2'd1) begin
            head_data_reg <= cap_data;
            head_src_reg  <= infl_src_reg;
          end else begin
            head_data_reg <= tail_data_reg;
            head_src_reg  <= tail_src_reg;
            tail_data_reg <= cap_data;
            tail_src_reg  <= infl_src_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign data_out = head_data_reg;
  assign src_out  = head_src_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NPORT; gi++) begin : g_cnt
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_reg[gi] <= '0;
        end else if (init) begin
          cnt_reg[gi] <= '0;
        end else if (deq && (head_src_reg == port_idx_t'(gi))) begin
          cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign cnt4 = cnt_reg[0];
  assign cnt5 = cnt_reg[1];
  assign cnt6 = cnt_reg[2];
  assign cnt7 = cnt_reg[3];

  assign idle = !reset || ((occ_reg == 2'd0) && !infl_reg && (&empty_vec));

endmodule

// File: doc/output_drain_rr.md
# output_drain_rr

Downstream drain stage for the 4-port switch. It pops the four output FIFOs (ports 4–7) round-robin and merges them into one 10-bit stream with a valid/ready handshake. It tags each word with its source port and keeps per-port delivered-word counters. The block absorbs the FIFOs' one-cycle read latency through a 2-entry output buffer, so backpressure never loses a word.

## Interface
Parameters:
- DATA_W, 10, word width: [9:8] destination class, [7:0] payload
- CNT_W, 8, per-port counter width (wraps)

Ports:
- clk  in  1  single clock; all logic on posedge
- reset  in  1  asynchronous, active-low; clears all state
- init  in  1  synchronous; holds counters at 0 and suppresses new pops while high
- empty4..empty7  in  1 each  output-FIFO empty flags; registered; reflect a pop one cycle later
- fifo_data4..fifo_data7  in  DATA_W each  FIFO read data; valid the cycle after the matching pop
- pop4..pop7  out  1 each  FIFO pop strobes; at most one high per cycle
- data_out  out  DATA_W  head word of output buffer
- src_out  out  2  source port of data_out (0 = port4 … 3 = port7)
- valid_out  out  1  data_out/src_out valid
- ready_in  in  1  consumer accepts when valid_out && ready_in
- cnt4..cnt7  out  CNT_W each  words delivered per source port
- idle  out  1  high when no buffered word, no in-flight pop, all FIFOs empty

## Operation
- Reset values: pop4..7=0, valid_out=0, data_out=0, src_out=0, cnt4..7=0, idle=1, RR pointer=3 (port4 searched first).
- Credit rule: in cycle t, pop the selected port iff occ + inflight − deq < 2.
  - occ is buffer occupancy (0..2).
  - inflight = 1 if a pop was issued in t−1.
  - deq = valid_out && ready_in.
- Selection: first non-empty port scanning from (ptr+1) mod 4 upward. The pointer moves to the granted port only when a pop is issued.
- Capture: the word from fifo_data[src] is written to the buffer tail in the cycle after the pop, with its src tag.
- Buffer: 2-entry FIFO. Enqueue and dequeue may occur in the same cycle. The credit rule makes overflow impossible, so no overflow check is needed.
- Counters: cnt[src_out] += 1 on each deq, wrapping at 2^CNT_W. They are held at 0 while init=1, and deqs during init are not counted.
- init=1 stops new pops. In-flight and buffered words still complete and are delivered normally.
- Reset mid-operation: all state is cleared immediately. Buffered and in-flight words are discarded.

## Timing
- Latency: pop in cycle t → word captured at the end of t+1 → valid_out in t+2.
- With ready_in=1 and a non-empty source, a pop issues every cycle (throughput 1 word/cycle).
- ready_in low: at most 2 words are outstanding (buffer + in-flight) and pops stall. valid_out and data_out stay stable until accepted.
- idle is combinational from registered state and the empty flags.

## Structure
- Package drain_pkg holds:
  - DATA_W and NPORT=4.
  - The port-index type (2 bits).
  - PORT_BASE=4, used for naming and documentation.
- Sub-module rr_arbiter4 holds the 4-request round-robin: inputs req[3:0], ptr, en; outputs grant one-hot and grant_idx. It is instantiated once.
- The top level contains the credit logic, the 2-entry buffer, and the counters.

## Test plan
- Reset: reset=0 with random inputs. Expect all pops 0, valid_out=0, cnt4..7=0, idle=1; release reset and expect no pop while all emptys are 1.
- Single word: port5 holds 10'h1EE with ready_in=1. Expect pop5 for exactly 1 cycle. Two cycles later expect data_out=10'h1EE, src_out=1, valid_out=1; cnt5 becomes 1.
- Round robin: each of ports 4–7 holds 2 words (8'hFF, EE, DD, CC), ready_in=1. Expect pop order 4,5,6,7,4,5,6,7 on consecutive cycles; 8 back-to-back valid cycles; each cnt=2.
- Backpressure: 4 words queued and ready_in=0. Expect exactly 2 pops and then a stall with data_out stable. Raise ready_in and expect the remaining words in RR order with no loss or duplication.
- init mid-stream: assert init one cycle after a pop. Expect no new pops, the in-flight word still delivered, and cnt held at 0. Deassert init and expect pops and counting to resume.
- Wrap and reset abort: deliver 256 words from port4 and expect cnt4 to wrap to 0. Then assert reset with 2 words outstanding: expect valid_out=0 asynchronously and nothing delivered after release.
